// File: rtl/branch_resolve_queue_if.sv
// rtl/branch_resolve_queue_if.sv - Branch FU result ports and resolved-branch output of the branch resolve queue
interface branch_resolve_queue_if #(
  parameter int NUM_BR_FU = 2,
  parameter int B_MASK    = 4,
  parameter int ADDR      = 32
);
  typedef struct packed {
    logic [B_MASK-1:0] bmm;
    logic              bm_mispred;
    logic [ADDR-1:0]   target_pc;
    logic              taken;
  } branch_reg_packet_t;

  logic [NUM_BR_FU-1:0]             fu_valid;
  logic [NUM_BR_FU-1:0][B_MASK-1:0] fu_bmm;
  logic [NUM_BR_FU-1:0][B_MASK-1:0] fu_b_mask;
  logic [NUM_BR_FU-1:0]             fu_is_jump;
  logic [NUM_BR_FU-1:0]             fu_pred_taken;
  logic [NUM_BR_FU-1:0]             fu_actual_taken;
  logic [NUM_BR_FU-1:0][ADDR-1:0]   fu_pred_target;
  logic [NUM_BR_FU-1:0][ADDR-1:0]   fu_actual_target;
  logic                             brq_ready;
  branch_reg_packet_t               branch_completing;

  modport master (
    output fu_valid, fu_bmm, fu_b_mask, fu_is_jump, fu_pred_taken, fu_actual_taken,
           fu_pred_target, fu_actual_target,
    input  brq_ready, branch_completing
  );

  modport slave (
    input  fu_valid, fu_bmm, fu_b_mask, fu_is_jump, fu_pred_taken, fu_actual_taken,
           fu_pred_target, fu_actual_target,
    output brq_ready, branch_completing
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - Circular queue of resolved branches, one completion per cycle
// with branch-mask clearing and squash of dependents of a mispredicted branch.
module branch_resolve_queue #(
  parameter int BRQ_DEPTH = 8,
  parameter int NUM_BR_FU = 2,
  parameter int B_MASK    = 4,
  parameter int ADDR      = 32
) (
  input logic                   clock,
  input logic                   reset,
  branch_resolve_queue_if.slave brq
);
  localparam int PTR_W = $clog2(BRQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]     head, tail;
  logic                 full;
  logic [BRQ_DEPTH-1:0] valid;
  logic [BRQ_DEPTH-1:0] e_mispred;
  logic [BRQ_DEPTH-1:0] e_taken;
  logic [B_MASK-1:0]    e_bmm    [BRQ_DEPTH];
  logic [B_MASK-1:0]    e_b_mask [BRQ_DEPTH];
  logic [ADDR-1:0]      e_target [BRQ_DEPTH];

  logic [CNT_W-1:0]     count, count_next, adv, nwr, sel_dist;
  logic [PTR_W-1:0]     sel, scan_idx;
  logic                 found;
  logic [B_MASK-1:0]    res_bmm;
  logic                 res_mis;
  logic                 res_taken;
  logic [ADDR-1:0]      res_target;
  logic [NUM_BR_FU-1:0] in_mis, accept;
  logic [PTR_W-1:0]     wr_idx [NUM_BR_FU];

  // Occupancy counts holes left by squashed entries until head skips past them.
  assign count         = full ? CNT_W'(BRQ_DEPTH) : {1'b0, tail - head};
  assign brq.brq_ready = (count <= CNT_W'(BRQ_DEPTH - NUM_BR_FU));

  always_comb begin
    found    = 1'b0;
    sel      = head;
    sel_dist = '0;
    scan_idx = '0;
    for (int i = BRQ_DEPTH - 1; i >= 0; i--) begin
      scan_idx = head + PTR_W'(i);
      if (valid[scan_idx]) begin
        found    = 1'b1;
        sel      = scan_idx;
        sel_dist = CNT_W'(i);
      end
    end
  end

  assign res_bmm    = found ? e_bmm[sel] : '0;
  assign res_mis    = found & e_mispred[sel];
  assign res_taken  = found & e_taken[sel];
  assign res_target = found ? e_target[sel] : '0;
  assign brq.branch_completing = {res_bmm, res_mis, res_target, res_taken};

  always_comb begin
    nwr = '0;
    for (int p = 0; p < NUM_BR_FU; p++) begin
      in_mis[p] = !brq.fu_is_jump[p] &&
                  ((brq.fu_actual_taken[p] != brq.fu_pred_taken[p]) ||
                   (brq.fu_actual_taken[p] && (brq.fu_actual_target[p] != brq.fu_pred_target[p])));
      accept[p] = brq.fu_valid[p] && !(res_mis && (|(brq.fu_b_mask[p] & res_bmm)));
      wr_idx[p] = tail + nwr[PTR_W-1:0];
      if (accept[p]) nwr = nwr + CNT_W'(1);
    end
    adv        = found ? sel_dist + CNT_W'(1) : count;
    count_next = count - adv + nwr;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      full  <= 1'b0;
      valid <= '0;
    end else begin
      head <= found ? sel + PTR_W'(1) : tail;
      tail <= tail + nwr[PTR_W-1:0];
      full <= (count_next == CNT_W'(BRQ_DEPTH));
      for (int j = 0; j < BRQ_DEPTH; j++) begin
        if (valid[j]) begin
          if (found && (PTR_W'(j) == sel)) begin
            valid[j] <= 1'b0;
          end else if (res_mis && (|(e_b_mask[j] & res_bmm))) begin
            valid[j] <= 1'b0;
          end else begin
            e_b_mask[j] <= e_b_mask[j] & ~res_bmm;
          end
        end
      end
      for (int p = 0; p < NUM_BR_FU; p++) begin
        if (accept[p]) begin
          valid[wr_idx[p]]     <= 1'b1;
          e_bmm[wr_idx[p]]     <= brq.fu_bmm[p];
          e_b_mask[wr_idx[p]]  <= brq.fu_b_mask[p] & ~res_bmm;
          e_mispred[wr_idx[p]] <= in_mis[p];
          e_taken[wr_idx[p]]   <= brq.fu_actual_taken[p];
          e_target[wr_idx[p]]  <= brq.fu_actual_target[p];
        end
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - Table-driven and sequence bench for branch_resolve_queue
module tb_branch_resolve_queue;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  branch_resolve_queue_if #(.NUM_BR_FU(2), .B_MASK(4), .ADDR(32)) bif ();

  branch_resolve_queue #(.BRQ_DEPTH(8), .NUM_BR_FU(2), .B_MASK(4), .ADDR(32)) dut (
    .clock(clock),
    .reset(reset),
    .brq  (bif)
  );

  typedef struct {
    logic [1:0]       v;
    logic [1:0][3:0]  bmm;
    logic [1:0][3:0]  bm;
    logic [1:0]       jmp;
    logic [1:0]       pt;
    logic [1:0]       at;
    logic [1:0][31:0] ptg;
    logic [1:0][31:0] atg;
    logic [3:0]       e_bmm;
    logic             e_mis;
    logic             e_taken;
    logic [31:0]      e_tgt;
    logic             e_rdy;
  } vec_t;

  localparam int NROWS = 15;
  vec_t tbl [NROWS];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] bmm, input logic mis,
                         input logic taken, input logic [31:0] tgt, input logic rdy);
    chk({tag, ".bmm"},   32'(bif.branch_completing.bmm), 32'(bmm));
    chk({tag, ".mis"},   32'(bif.branch_completing.bm_mispred), 32'(mis));
    chk({tag, ".taken"}, 32'(bif.branch_completing.taken), 32'(taken));
    chk({tag, ".tgt"},   bif.branch_completing.target_pc, tgt);
    chk({tag, ".ready"}, 32'(bif.brq_ready), 32'(rdy));
  endtask

  task automatic clear_inputs();
    bif.fu_valid = '0; bif.fu_bmm = '0; bif.fu_b_mask = '0; bif.fu_is_jump = '0;
    bif.fu_pred_taken = '0; bif.fu_actual_taken = '0;
    bif.fu_pred_target = '0; bif.fu_actual_target = '0;
  endtask

  task automatic drive_port(input int p, input logic [3:0] bmm, input logic [3:0] bm, input logic jmp,
                            input logic pt, input logic at, input logic [31:0] ptg, input logic [31:0] atg);
    bif.fu_valid[p] = 1'b1; bif.fu_bmm[p] = bmm; bif.fu_b_mask[p] = bm; bif.fu_is_jump[p] = jmp;
    bif.fu_pred_taken[p] = pt; bif.fu_actual_taken[p] = at;
    bif.fu_pred_target[p] = ptg; bif.fu_actual_target[p] = atg;
  endtask

  task automatic set_port(input int r, input int p, input logic [3:0] bmm, input logic [3:0] bm, input logic jmp,
                          input logic pt, input logic at, input logic [31:0] ptg, input logic [31:0] atg);
    tbl[r].v[p] = 1'b1; tbl[r].bmm[p] = bmm; tbl[r].bm[p] = bm; tbl[r].jmp[p] = jmp;
    tbl[r].pt[p] = pt; tbl[r].at[p] = at; tbl[r].ptg[p] = ptg; tbl[r].atg[p] = atg;
  endtask

  task automatic set_exp(input int r, input logic [3:0] bmm, input logic mis, input logic taken, input logic [31:0] tgt);
    tbl[r].e_bmm = bmm; tbl[r].e_mis = mis; tbl[r].e_taken = taken; tbl[r].e_tgt = tgt;
  endtask

  always @(posedge clock) begin
    if (!reset && (|bif.fu_valid) && !bif.brq_ready) begin
      failures++;
      $display("FAIL protocol write_while_not_ready actual=0x%0h required=0x0", bif.fu_valid);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int          exp_cnt;
  int          cur;
  int          guard;
  int          k;
  bit          filling;
  bit          saw_full;
  logic [31:0] sb_t [$];
  logic [3:0]  sb_b [$];
  logic [3:0]  one;

  initial begin
    for (int i = 0; i < NROWS; i++) begin
      tbl[i] = '{default: '0};
      tbl[i].e_rdy = 1'b1;
    end
    // Single mispredicted branch, then a correct pair in port order
    set_port(0, 0, 4'b0001, 4'b0000, 0, 0, 1, 32'h1000, 32'h1040);
    set_exp (1, 4'b0001, 1, 1, 32'h1040);
    set_port(2, 0, 4'b0001, 4'b0000, 0, 1, 1, 32'h2000, 32'h2000);
    set_port(2, 1, 4'b0010, 4'b0000, 0, 0, 0, 32'h3000, 32'h3000);
    set_exp (3, 4'b0001, 0, 1, 32'h2000);
    set_exp (4, 4'b0010, 0, 0, 32'h3000);
    // Mask clearing of incoming D, then squash of incoming F while W resolves wrong
    set_port(5, 0, 4'b0001, 4'b0000, 0, 0, 0, 32'h4000, 32'h4000);
    set_port(5, 1, 4'b0001, 4'b0000, 0, 1, 0, 32'h4200, 32'h4100);
    set_exp (6, 4'b0001, 0, 0, 32'h4000);
    set_port(6, 0, 4'b0100, 4'b0011, 0, 0, 1, 32'h5000, 32'h5040);
    set_exp (7, 4'b0001, 1, 0, 32'h4100);
    set_port(7, 0, 4'b1000, 4'b0001, 0, 0, 0, 32'hF000, 32'hF000);
    set_port(7, 1, 4'b0010, 4'b0000, 0, 0, 0, 32'h9000, 32'h9000);
    set_exp (8, 4'b0100, 1, 1, 32'h5040);
    set_exp (9, 4'b0010, 0, 0, 32'h9000);
    // Jump with wrong target, taken branch with wrong target, not-taken direction miss
    set_port(9, 0, 4'b0001, 4'b0000, 1, 1, 1, 32'h6000, 32'h6800);
    set_port(9, 1, 4'b0010, 4'b0000, 0, 1, 1, 32'h7000, 32'h7100);
    set_exp (10, 4'b0001, 0, 1, 32'h6800);
    set_exp (11, 4'b0010, 1, 1, 32'h7100);
    set_port(12, 1, 4'b0100, 4'b0000, 0, 1, 0, 32'h8000, 32'h8000);
    set_exp (13, 4'b0100, 1, 0, 32'h8000);

    clear_inputs();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk_out("reset", 4'b0000, 0, 0, 32'h0, 1);
    reset = 1'b0;

    for (int i = 0; i < NROWS; i++) begin
      chk_out($sformatf("row%0d", i), tbl[i].e_bmm, tbl[i].e_mis, tbl[i].e_taken, tbl[i].e_tgt, tbl[i].e_rdy);
      bif.fu_valid = tbl[i].v; bif.fu_bmm = tbl[i].bmm; bif.fu_b_mask = tbl[i].bm;
      bif.fu_is_jump = tbl[i].jmp; bif.fu_pred_taken = tbl[i].pt; bif.fu_actual_taken = tbl[i].at;
      bif.fu_pred_target = tbl[i].ptg; bif.fu_actual_target = tbl[i].atg;
      @(negedge clock);
    end
    clear_inputs();

    // Fill to the ready threshold and drain, wrapping the pointers
    exp_cnt = 0; guard = 0; k = 0; filling = 1'b1; saw_full = 1'b0;
    while ((filling || sb_t.size() > 0) && guard < 40) begin
      guard++;
      cur = exp_cnt;
      chk("fill.ready", 32'(bif.brq_ready), 32'(cur <= 6));
      if (sb_t.size() > 0) begin
        chk("fill.bmm", 32'(bif.branch_completing.bmm), 32'(sb_b[0]));
        chk("fill.tgt", bif.branch_completing.target_pc, sb_t[0]);
        void'(sb_t.pop_front());
        void'(sb_b.pop_front());
        exp_cnt--;
      end else begin
        chk("fill.idle", 32'(bif.branch_completing.bmm), 32'h0);
      end
      clear_inputs();
      if (filling) begin
        if (cur <= 6) begin
          for (int p = 0; p < 2; p++) begin
            one = 4'b0001 << (k % 4);
            drive_port(p, one, 4'b0000, 0, 0, 0, 32'h100 + 32'(k), 32'h100 + 32'(k));
            sb_t.push_back(32'h100 + 32'(k));
            sb_b.push_back(one);
            k++;
            exp_cnt++;
          end
        end else begin
          saw_full = 1'b1;
          filling  = 1'b0;
        end
      end
      @(negedge clock);
    end
    clear_inputs();
    chk("fill.reached_not_ready", 32'(saw_full), 32'h1);
    chk_out("fill.drained", 4'b0000, 0, 0, 32'h0, 1);

    // A mispredicted, B (depends on A) squashed in the queue, C survives
    drive_port(0, 4'b0001, 4'b0000, 0, 0, 1, 32'hA000, 32'hA0A0);
    drive_port(1, 4'b0010, 4'b0001, 0, 1, 1, 32'hB000, 32'hB000);
    @(negedge clock);
    clear_inputs();
    chk_out("squash.a", 4'b0001, 1, 1, 32'hA0A0, 1);
    drive_port(0, 4'b0100, 4'b0000, 0, 1, 1, 32'hC000, 32'hC000);
    @(negedge clock);
    clear_inputs();
    chk_out("squash.c", 4'b0100, 0, 1, 32'hC000, 1);
    @(negedge clock);
    chk_out("squash.idle", 4'b0000, 0, 0, 32'h0, 1);

    // Reset with 5 entries queued and 2 more arriving
    for (int n = 0; n < 4; n++) begin
      clear_inputs();
      drive_port(0, 4'b0001, 4'b0000, 0, 0, 0, 32'h700 + 32'(2 * n), 32'h700 + 32'(2 * n));
      drive_port(1, 4'b0010, 4'b0000, 0, 0, 0, 32'h701 + 32'(2 * n), 32'h701 + 32'(2 * n));
      @(negedge clock);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    clear_inputs();
    chk_out("rst.first", 4'b0000, 0, 0, 32'h0, 1);
    @(negedge clock);
    chk_out("rst.second", 4'b0000, 0, 0, 32'h0, 1);
    drive_port(1, 4'b1000, 4'b0000, 0, 1, 1, 32'hD000, 32'hD000);
    @(negedge clock);
    clear_inputs();
    chk_out("rst.after", 4'b1000, 0, 1, 32'hD000, 1);
    @(negedge clock);
    chk_out("rst.idle", 4'b0000, 0, 0, 32'h0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 SHALL have parameter BRQ_DEPTH, default 8, meaning queue entry count (power of 2, >= 2*NUM_BR_FU).
REQ-002 SHALL have parameter NUM_BR_FU, default 2, meaning branch functional-unit result ports.
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 fu_valid  input  NUM_BR_FU  per-port resolved-branch result valid.
REQ-006 fu_bmm  input  NUM_BR_FU x B_MASK  one-hot branch-mask bit owned by the resolving branch.
REQ-007 fu_b_mask  input  NUM_BR_FU x B_MASK  older-branch dependency mask of the resolving branch.
REQ-008 fu_is_jump  input  NUM_BR_FU  result is a jump, not a conditional branch.
REQ-009 fu_pred_taken / fu_actual_taken  input  NUM_BR_FU each  predicted and resolved direction.
REQ-010 fu_pred_target / fu_actual_target  input  NUM_BR_FU x ADDR each  predicted and resolved target.
REQ-011 brq_ready  output  1  high when free slots >= NUM_BR_FU; issue stalls branch FUs when low.
REQ-012 branch_completing  output  BRANCH_REG_PACKET  fields bmm, bm_mispred, target_PC, taken to branch stack.

Function
REQ-013 Circular buffer: head, tail pointers (log2 BRQ_DEPTH bits, wrap modulo BRQ_DEPTH), per-entry valid bit, occupancy = tail-head with full flag distinguishing tail==head.
REQ-014 Enqueue: valid ports written at tail in port order (port 0 first), tail advances by number written; at most one write per port per cycle.
REQ-015 Writes with brq_ready low are a protocol violation; queue behaviour then undefined, bench asserts none occur.
REQ-016 Output combinational from state: selected entry = first valid entry at or after head; none valid -> branch_completing all zero (bmm='0 means idle).
REQ-017 Dequeue one entry per cycle: selected entry invalidated; head moves to selected index+1; if no valid entry, head moves to tail.
REQ-018 bm_mispred = !is_jump && (actual_taken != pred_taken || (actual_taken && actual_target != pred_target)); jumps always bm_mispred=0.
REQ-019 taken = actual_taken; target_PC = actual_target, passed unchanged.
REQ-020 Minimum latency: result enqueued on edge N, earliest presentation cycle N+1; no same-cycle bypass.
REQ-021 Resolve clearing: every cycle with nonzero output bmm R, all remaining queued entries and all incoming ports SHALL have b_mask &= ~R before storing.
REQ-022 Squash: if output bm_mispred=1, every queued entry and incoming port with (b_mask & R) != 0 SHALL be invalidated/dropped; tail not rewound; holes skipped per REQ-017.
REQ-023 Dropped incoming ports still consume no slot; tail advances only by ports actually written.
REQ-024 Empty and full: empty -> idle output, brq_ready=1; occupancy > BRQ_DEPTH-NUM_BR_FU -> brq_ready=0 same cycle, registered from state.
REQ-025 Simultaneous enqueue and dequeue allowed in one cycle; occupancy updates by writes minus head advance.
REQ-026 Only one branch_completing per cycle; queued order is arrival order, not program order.

Reset
REQ-027 On reset: head=tail=0, all valid bits 0, full flag 0, branch_completing='0, brq_ready=1.
REQ-028 Reset mid-operation SHALL discard all entries, including those being written that cycle; first output after deassertion is idle.
REQ-029 No output X after reset; stored payload need not be cleared.

Verification
REQ-030 Single branch port0 bmm=0001, pred_taken=0, actual_taken=1, target=0x1040 at edge 0 -> cycle 1 bmm=0001, bm_mispred=1, taken=1, target_PC=0x1040; cycle 2 idle.
REQ-031 Ports 0,1 same cycle bmm=0001,0010 both correct -> port0 entry cycle 1, port1 entry cycle 2, both bm_mispred=0.
REQ-032 Queue holds A bmm=0001 mispredicted, B bmm=0010 b_mask=0001, C bmm=0100 b_mask=0000 -> A output, B squashed, C output next cycle with bm_mispred per its fields.
REQ-033 Correct A bmm=0001 output while incoming D b_mask=0011 -> D stored with b_mask=0010.
REQ-034 Fill to 7 of 8 entries with no dequeue -> brq_ready=0; drain -> brq_ready=1 once occupancy <= 6; pointers wrap past index 7 to 0 correctly.
REQ-035 Jump with actual_target != pred_target -> bm_mispred=0; reset asserted with 5 entries queued -> next cycle idle, brq_ready=1.
